// File: rtl/ro_puf_race_ctrl.sv
// Sequenced ring-oscillator PUF race controller.
// Runs NUM_RACES races between two RO edge streams, captures a slice of the
// losing counter after each race and packs the slices into one response word.
module ro_puf_race_ctrl #(
  parameter int CNT_W         = 16,
  parameter int BIT_LSB       = 5,
  parameter int BITS_PER_RACE = 3,
  parameter int NUM_RACES     = 4,
  parameter int TIMEOUT_W     = 20,
  localparam int IDX_W        = (NUM_RACES > 1) ? $clog2(NUM_RACES) : 1,
  localparam int RESP_W       = NUM_RACES * BITS_PER_RACE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ro_edge_a,
  input  logic              ro_edge_b,
  output logic              ro_en,
  output logic              busy,
  output logic              done,
  output logic [RESP_W-1:0] response,
  output logic [IDX_W-1:0]  race_idx,
  output logic              tie_flag,
  output logic              timeout_err
);

  if (BIT_LSB + BITS_PER_RACE > CNT_W) begin : g_bad_slice
    $error("ro_puf_race_ctrl: BIT_LSB+BITS_PER_RACE exceeds CNT_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RACE,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt_a;
  logic [CNT_W-1:0]         cnt_b;
  logic [TIMEOUT_W-1:0]     wd;
  logic [BITS_PER_RACE-1:0] loser_slice;

  logic [CNT_W-1:0]         a_nxt;
  logic [CNT_W-1:0]         b_nxt;
  logic [TIMEOUT_W-1:0]     wd_nxt;
  logic                     ovf_a;
  logic                     ovf_b;
  logic [BITS_PER_RACE-1:0] slice_nxt;

  // Post-increment counter values and overflow detection for the current RACE cycle.
  // Only the captured slice of the loser is kept; on a tie B has wrapped to 0.
  always_comb begin
    a_nxt     = cnt_a + CNT_W'(ro_edge_a);
    b_nxt     = cnt_b + CNT_W'(ro_edge_b);
    wd_nxt    = wd + TIMEOUT_W'(1);
    ovf_a     = ro_edge_a && (cnt_a == '1);
    ovf_b     = ro_edge_b && (cnt_b == '1);
    slice_nxt = ovf_a ? b_nxt[BIT_LSB +: BITS_PER_RACE]
                      : a_nxt[BIT_LSB +: BITS_PER_RACE];
  end

  // Race sequencer: state, counters, watchdog and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt_a       <= '0;
      cnt_b       <= '0;
      wd          <= '0;
      loser_slice <= '0;
      race_idx    <= '0;
      response    <= '0;
      ro_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tie_flag    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          race_idx <= '0;
          if (start) begin
            state       <= S_CLEAR;
            busy        <= 1'b1;
            response    <= '0;
            tie_flag    <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_CLEAR: begin
          cnt_a <= '0;
          cnt_b <= '0;
          wd    <= '0;
          ro_en <= 1'b1;
          state <= S_RACE;
        end
        S_RACE: begin
          cnt_a <= a_nxt;
          cnt_b <= b_nxt;
          wd    <= wd_nxt;
          // Overflow takes priority over the watchdog expiring in the same cycle.
          if (ovf_a || ovf_b) begin
            loser_slice <= slice_nxt;
            if (ovf_a && ovf_b) tie_flag <= 1'b1;
            ro_en <= 1'b0;
            state <= S_CAPTURE;
          end else if (wd_nxt == '1) begin
            timeout_err <= 1'b1;
            ro_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_FINISH;
          end
        end
        S_CAPTURE: begin
          response[race_idx * BITS_PER_RACE +: BITS_PER_RACE] <= loser_slice;
          if (race_idx == IDX_W'(NUM_RACES - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            race_idx <= race_idx + IDX_W'(1);
            state    <= S_CLEAR;
          end
        end
        S_FINISH: begin
          race_idx <= '0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
